// File: rtl/blit_pkg.sv
// Shared types and default sizing for the blitter memory cycle sequencer.
package blit_pkg;

   localparam int unsigned BLIT_NCH_DEF = 3;
   localparam int unsigned BLIT_WSW_DEF = 3;

   // Memory cycle phases: idle, address/start tick, wait ticks, end tick.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T1   = 2'd1,
      ST_TW   = 2'd2,
      ST_T2   = 2'd3
   } blit_state_e;

   // True while a memory cycle owns the bus (T1, TW or T2).
   function automatic logic in_cycle(input blit_state_e st);
      return (st != ST_IDLE);
   endfunction

endpackage

// File: rtl/blit_prio_arb.sv
// Fixed-priority arbiter: the lowest-index requester wins, result is one-hot.
module blit_prio_arb #(
   parameter int NCH = 3
) (
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt
);

   logic found_s;

   // Scan from channel 0 upwards; once a requester is found all later ones are masked.
   always_comb begin
      gnt     = {NCH{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         gnt[i]  = req[i] & ~found_s;
         found_s = found_s | req[i];
      end
   end

endmodule

// File: rtl/blit_mem_seq.sv
// Blitter memory cycle sequencer: arbitrates cycle requests, runs the
// T1/TW/T2 timing with programmed and external wait states, and drives
// registered memory strobes plus cycle-position flags.
module blit_mem_seq
   import blit_pkg::*;
#(
   parameter int NCH = BLIT_NCH_DEF,
   parameter int WSW = BLIT_WSW_DEF
) (
   input  logic           CCLK,
   input  logic           RESETL,
   input  logic [NCH-1:0] CRQ,
   input  logic           ACKINT,
   input  logic           WAITL,
   input  logic [WSW-1:0] WSTATES,
   input  logic [NCH-1:0] DSTWR,
   input  logic [NCH-1:0] WRES,
   input  logic           INHIB,
   output logic           BMREQ,
   output logic           BRD,
   output logic           BWR,
   output logic           BWORD,
   output logic           DATOEL,
   output logic           CYCST,
   output logic           CYCEND,
   output logic           ICYCST,
   output logic           ICYCEND,
   output logic [NCH-1:0] GNT,
   output logic [NCH-1:0] UPD
);

   localparam logic [WSW-1:0] CNT_ZERO = {WSW{1'b0}};
   localparam logic [WSW-1:0] CNT_ONE  = WSW'(1'b1);
   localparam logic [NCH-1:0] CH_NONE  = {NCH{1'b0}};

   blit_state_e    state_r, nxt_state_s;
   logic [WSW-1:0] cnt_r, nxt_cnt_s, dec_cnt_s;
   logic [NCH-1:0] gnt_r, nxt_gnt_s, arb_gnt_s, upd_r;
   logic           wr_r, wres_r, nxt_wr_s, nxt_wres_s;
   logic           start_s, nxt_act_s, nxt_bwr_s;
   logic           bmreq_r, brd_r, bwr_r, bword_r, datoel_r, cycst_r, cycend_r;

   blit_prio_arb #(.NCH(NCH)) u_arb (
      .req (CRQ),
      .gnt (arb_gnt_s)
   );

   assign start_s   = ACKINT & (|CRQ);
   // The counter holds the programmed waits still owed after the current tick.
   assign dec_cnt_s = (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : cnt_r;

   // Next-state decode; a new cycle latches owner, direction and width so later CRQ changes are ignored.
   always_comb begin
      nxt_state_s = state_r;
      nxt_cnt_s   = cnt_r;
      nxt_gnt_s   = gnt_r;
      nxt_wr_s    = wr_r;
      nxt_wres_s  = wres_r;
      if (!RESETL) begin
         nxt_state_s = ST_IDLE;
         nxt_cnt_s   = CNT_ZERO;
         nxt_gnt_s   = CH_NONE;
         nxt_wr_s    = 1'b0;
         nxt_wres_s  = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_T2: begin
               if (start_s) begin
                  nxt_state_s = ST_T1;
                  nxt_cnt_s   = WSTATES;
                  nxt_gnt_s   = arb_gnt_s;
                  nxt_wr_s    = |(DSTWR & arb_gnt_s);
                  nxt_wres_s  = |(WRES & arb_gnt_s);
               end else begin
                  nxt_state_s = ST_IDLE;
                  nxt_cnt_s   = CNT_ZERO;
                  nxt_gnt_s   = CH_NONE;
                  nxt_wr_s    = 1'b0;
                  nxt_wres_s  = 1'b0;
               end
            end
            ST_T1: begin
               if ((cnt_r != CNT_ZERO) || !WAITL) begin
                  nxt_state_s = ST_TW;
                  nxt_cnt_s   = dec_cnt_s;
               end else begin
                  nxt_state_s = ST_T2;
               end
            end
            ST_TW: begin
               if ((cnt_r == CNT_ZERO) && WAITL) begin
                  nxt_state_s = ST_T2;
               end else begin
                  nxt_state_s = ST_TW;
                  nxt_cnt_s   = dec_cnt_s;
               end
            end
            default: begin
               nxt_state_s = ST_IDLE;
               nxt_cnt_s   = CNT_ZERO;
               nxt_gnt_s   = CH_NONE;
               nxt_wr_s    = 1'b0;
               nxt_wres_s  = 1'b0;
            end
         endcase
      end
   end

   assign nxt_act_s = in_cycle(nxt_state_s);
   assign nxt_bwr_s = nxt_act_s & nxt_wr_s & ~INHIB;

   // Sequencer state, wait counter and latched cycle attributes.
   always_ff @(posedge CCLK) begin
      if (!RESETL) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         gnt_r   <= CH_NONE;
         wr_r    <= 1'b0;
         wres_r  <= 1'b0;
      end else begin
         state_r <= nxt_state_s;
         cnt_r   <= nxt_cnt_s;
         gnt_r   <= nxt_gnt_s;
         wr_r    <= nxt_wr_s;
         wres_r  <= nxt_wres_s;
      end
   end

   // Registered strobes: each reflects the phase being entered; write data is enabled from the second write tick.
   always_ff @(posedge CCLK) begin
      if (!RESETL) begin
         bmreq_r  <= 1'b0;
         brd_r    <= 1'b0;
         bwr_r    <= 1'b0;
         bword_r  <= 1'b0;
         datoel_r <= 1'b1;
         cycst_r  <= 1'b0;
         cycend_r <= 1'b0;
         upd_r    <= CH_NONE;
      end else begin
         bmreq_r  <= ((nxt_state_s == ST_T1) || (nxt_state_s == ST_TW)) & ~(nxt_wr_s & INHIB);
         brd_r    <= nxt_act_s & ~nxt_wr_s;
         bwr_r    <= nxt_bwr_s;
         bword_r  <= nxt_act_s & nxt_wres_s;
         datoel_r <= ~(nxt_bwr_s & bwr_r);
         cycst_r  <= (nxt_state_s == ST_T1);
         cycend_r <= (nxt_state_s == ST_T2);
         upd_r    <= (state_r == ST_T2) ? gnt_r : CH_NONE;
      end
   end

   assign BMREQ   = bmreq_r;
   assign BRD     = brd_r;
   assign BWR     = bwr_r;
   assign BWORD   = bword_r;
   assign DATOEL  = datoel_r;
   assign CYCST   = cycst_r;
   assign CYCEND  = cycend_r;
   assign ICYCST  = (nxt_state_s == ST_T1);
   assign ICYCEND = (nxt_state_s == ST_T2);
   assign GNT     = gnt_r;
   assign UPD     = upd_r;

endmodule
